// File: rtl/cam_pkg.sv
// Shared definitions for the camera front end: FSM state encoding, default pixel
// width and the sizing rule for the position counters.
package cam_pkg;

  localparam int CAM_DW = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_VBLANK = 3'd1;
  localparam logic [2:0] ST_ACTIVE = 3'd2;
  localparam logic [2:0] ST_HBLANK = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // A counter that must hold the value max_val itself (saturation point).
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cam_edge_det.sv
// Registers a sensor control line once and flags its rising/falling edges
// against the previous registered value; 1-cycle input latency.
module cam_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic prev,
  output logic rise,
  output logic fall
);

  logic q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= 1'b0;
      prev <= 1'b0;
    end else begin
      q    <= d;
      prev <= q;
    end
  end

  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/cam_frame_sync.sv
// Tracks frame/line/pixel position of the raw sensor bus and forwards a cropped,
// registered pixel stream with sof/eol markers; din at edge N reaches dout at N+2.
module cam_frame_sync
  import cam_pkg::*;
#(
  parameter int DW      = CAM_DW,
  parameter int MAX_W   = 640,
  parameter int MAX_H   = 480,
  parameter int CROP_X0 = 0,
  parameter int CROP_W  = 21,
  parameter int CROP_Y0 = 0,
  parameter int CROP_H  = 3
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          href,
  input  logic [DW-1:0] din,
  output logic          vsync_o,
  output logic          href_o,
  output logic [DW-1:0] dout,
  output logic          sof,
  output logic          eol,
  output logic          frame_err,
  output logic [15:0]   frame_cnt
);

  localparam int XW = cnt_width(MAX_W);
  localparam int YW = cnt_width(MAX_H);

  localparam logic [XW-1:0] X_MAX      = XW'(MAX_W);
  localparam logic [XW-1:0] X_BEG      = XW'(CROP_X0);
  localparam logic [XW-1:0] X_END      = XW'(CROP_X0 + CROP_W);
  localparam logic [XW-1:0] X_SPAN     = XW'(CROP_W);
  localparam logic [XW-1:0] X_LAST_REL = XW'(CROP_W - 1);
  localparam logic [YW-1:0] Y_MAX      = YW'(MAX_H);
  localparam logic [YW-1:0] Y_BEG      = YW'(CROP_Y0);
  localparam logic [YW-1:0] Y_END      = YW'(CROP_Y0 + CROP_H);
  localparam logic [YW-1:0] Y_SPAN     = YW'(CROP_H);

  logic          vs_rise, vs_prev_unused, vs_fall_unused;
  logic          hr_prev, hr_rise, hr_fall;
  logic [2:0]    state;
  logic [XW-1:0] x, x_inc, x_rel;
  logic [YW-1:0] y, y_inc, y_rel;
  logic          x_in, y_in;
  logic [DW-1:0] s_din, s_din_d;

  cam_edge_det u_vsync_det (
    .clk  (pclk),
    .rst  (rst),
    .d    (vsync),
    .prev (vs_prev_unused),
    .rise (vs_rise),
    .fall (vs_fall_unused)
  );

  cam_edge_det u_href_det (
    .clk  (pclk),
    .rst  (rst),
    .d    (href),
    .prev (hr_prev),
    .rise (hr_rise),
    .fall (hr_fall)
  );

  // Offsets wrap to large values below the window start, so one unsigned
  // compare covers both window bounds.
  assign x_inc = (x == X_MAX) ? x : x + 1'b1;
  assign y_inc = (y == Y_MAX) ? y : y + 1'b1;
  assign x_rel = x - X_BEG;
  assign y_rel = y - Y_BEG;
  assign x_in  = x_rel < X_SPAN;
  assign y_in  = y_rel < Y_SPAN;

  // In ACTIVE the pixel under consideration is the delayed href/din pair, so
  // the cycle that detects the href rise and the one that detects the fall
  // each still carry a valid pixel.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state     <= ST_IDLE;
      x         <= '0;
      y         <= '0;
      s_din     <= '0;
      s_din_d   <= '0;
      vsync_o   <= 1'b0;
      href_o    <= 1'b0;
      dout      <= '0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      s_din   <= din;
      s_din_d <= s_din;
      vsync_o <= vs_rise;
      href_o  <= 1'b0;
      sof     <= 1'b0;
      eol     <= 1'b0;
      if (vs_rise) begin
        state     <= ST_VBLANK;
        x         <= '0;
        y         <= '0;
        frame_err <= 1'b0;
        frame_cnt <= frame_cnt + 16'd1;
      end else begin
        case (state)
          ST_VBLANK: begin
            if (hr_rise) begin
              state <= ST_ACTIVE;
              x     <= '0;
            end
          end
          ST_ACTIVE: begin
            if (hr_prev) begin
              x <= x_inc;
              if (x_in && y_in) begin
                href_o <= 1'b1;
                dout   <= s_din_d;
                sof    <= (x_rel == '0) && (y_rel == '0);
                eol    <= (x_rel == X_LAST_REL);
              end
            end
            if (hr_fall) begin
              state <= ST_HBLANK;
              y     <= y_inc;
              if (y_in && (x_inc < X_END)) frame_err <= 1'b1;
            end
          end
          ST_HBLANK: begin
            if (hr_rise) begin
              if (y == Y_END) begin
                state <= ST_DONE;
              end else begin
                state <= ST_ACTIVE;
                x     <= '0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cam_frame_sync.sv
// Directed bench: full-window and cropped instances share one sensor stimulus;
// forwarded beats are captured per tick and checked against hand-computed values.
module tb_cam_frame_sync;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic [7:0]  din = 8'd0;

  logic        vsync_o1, href_o1, sof1, eol1, frame_err1;
  logic [7:0]  dout1;
  logic [15:0] frame_cnt1;
  logic        vsync_o2, href_o2, sof2, eol2, frame_err2;
  logic [7:0]  dout2;
  logic [15:0] frame_cnt2;

  always #5 pclk = ~pclk;

  cam_frame_sync u_full (
    .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .din(din),
    .vsync_o(vsync_o1), .href_o(href_o1), .dout(dout1), .sof(sof1), .eol(eol1),
    .frame_err(frame_err1), .frame_cnt(frame_cnt1)
  );

  cam_frame_sync #(.CROP_X0(2), .CROP_W(4), .CROP_Y0(1), .CROP_H(1)) u_crop (
    .pclk(pclk), .rst(rst), .vsync(vsync), .href(href), .din(din),
    .vsync_o(vsync_o2), .href_o(href_o2), .dout(dout2), .sof(sof2), .eol(eol2),
    .frame_err(frame_err2), .frame_cnt(frame_cnt2)
  );

  int checks = 0;
  int fails  = 0;
  int tcnt   = 0;
  int t0     = 0;

  int b1, s1, sd1, st1, vp1;
  int e1[$];
  int b2, s2, sd2;
  int e2[$];
  int dq2[$];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_cap();
    b1 = 0; s1 = 0; sd1 = -1; st1 = -1; vp1 = 0; e1.delete();
    b2 = 0; s2 = 0; sd2 = -1; e2.delete(); dq2.delete();
  endtask

  task automatic tick(input logic vs, input logic hr, input logic [7:0] d);
    vsync = vs; href = hr; din = d;
    @(posedge pclk);
    #1;
    tcnt++;
    if (vsync_o1) vp1++;
    if (href_o1) begin
      b1++;
      if (sof1) begin s1++; sd1 = int'(dout1); st1 = tcnt; end
      if (eol1) e1.push_back(int'(dout1));
    end
    if (href_o2) begin
      b2++;
      dq2.push_back(int'(dout2));
      if (sof2) begin s2++; sd2 = int'(dout2); end
      if (eol2) e2.push_back(int'(dout2));
    end
  endtask

  task automatic vs_pulse();
    tick(1'b1, 1'b0, 8'd0);
    tick(1'b1, 1'b0, 8'd0);
    repeat (4) tick(1'b0, 1'b0, 8'd0);
  endtask

  task automatic send_line(input int y, input int npix);
    for (int p = 0; p < npix; p++) tick(1'b0, 1'b1, 8'(p + y + 1));
    repeat (4) tick(1'b0, 1'b0, 8'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick(1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    repeat (2) tick(1'b0, 1'b0, 8'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_href_o"}, int'(href_o1), 0);
    chk({tag, "_dout"}, int'(dout1), 0);
    chk({tag, "_sof"}, int'(sof1), 0);
    chk({tag, "_eol"}, int'(eol1), 0);
    chk({tag, "_vsync_o"}, int'(vsync_o1), 0);
    chk({tag, "_frame_err"}, int'(frame_err1), 0);
    chk({tag, "_frame_cnt"}, int'(frame_cnt1), 0);
  endtask

  task automatic chk_full_eols(input string tag);
    chk({tag, "_eol_n"}, e1.size(), 3);
    for (int i = 0; i < 3; i++)
      chk({tag, "_eol_val"}, (i < e1.size()) ? e1[i] : -1, 21 + i);
  endtask

  initial begin
    clear_cap();

    // Reset state
    do_reset();
    chk_outputs_zero("reset");

    // Full window frame, plus cropped instance on the same stimulus
    clear_cap();
    vs_pulse();
    chk("f1_vsync_pulses", vp1, 1);
    t0 = tcnt + 1;
    send_line(0, 21);
    send_line(1, 21);
    send_line(2, 21);
    chk("f1_beats", b1, 63);
    chk("f1_sof_count", s1, 1);
    chk("f1_sof_dout", sd1, 1);
    chk("f1_sof_latency", st1 - t0, 2);
    chk_full_eols("f1");
    chk("f1_frame_cnt", int'(frame_cnt1), 1);
    chk("f1_frame_err", int'(frame_err1), 0);
    chk("crop_beats", b2, 4);
    for (int i = 0; i < 4; i++)
      chk("crop_dout", (i < dq2.size()) ? dq2[i] : -1, 4 + i);
    chk("crop_sof_count", s2, 1);
    chk("crop_sof_dout", sd2, 4);
    chk("crop_eol_n", e2.size(), 1);
    chk("crop_eol_val", (e2.size() > 0) ? e2[0] : -1, 7);

    // Short middle line
    clear_cap();
    vs_pulse();
    send_line(0, 21);
    chk("short_err_before", int'(frame_err1), 0);
    send_line(1, 15);
    chk("short_err_after", int'(frame_err1), 1);
    send_line(2, 21);
    chk("short_eol_n", e1.size(), 2);
    chk("short_eol0", (e1.size() > 0) ? e1[0] : -1, 21);
    chk("short_eol1", (e1.size() > 1) ? e1[1] : -1, 23);
    chk("short_err_held", int'(frame_err1), 1);
    vs_pulse();
    chk("short_err_cleared", int'(frame_err1), 0);
    chk("short_frame_cnt", int'(frame_cnt1), 3);

    // Pixels without any vsync after reset
    do_reset();
    clear_cap();
    send_line(0, 21);
    send_line(1, 21);
    send_line(2, 21);
    chk("novs_beats", b1, 0);
    chk("novs_frame_cnt", int'(frame_cnt1), 0);
    chk("novs_vsync_pulses", vp1, 0);

    // Reset asserted at pixel 10 of line 0
    clear_cap();
    vs_pulse();
    for (int p = 0; p < 10; p++) tick(1'b0, 1'b1, 8'(p + 1));
    chk("pre_rst_href_o", int'(href_o1), 1);
    rst = 1'b1;
    tick(1'b0, 1'b1, 8'd11);
    chk_outputs_zero("midrst");
    rst = 1'b0;
    for (int p = 11; p < 21; p++) tick(1'b0, 1'b1, 8'(p + 1));
    repeat (4) tick(1'b0, 1'b0, 8'd0);
    clear_cap();
    send_line(1, 21);
    send_line(2, 21);
    chk("midrst_ignored_beats", b1, 0);
    vs_pulse();
    send_line(0, 21);
    send_line(1, 21);
    send_line(2, 21);
    chk("midrst_beats", b1, 63);
    chk_full_eols("midrst");
    chk("midrst_frame_cnt", int'(frame_cnt1), 1);

    // vsync rise at pixel 8 of line 1 aborts the line
    clear_cap();
    vs_pulse();
    send_line(0, 21);
    for (int p = 0; p < 21; p++)
      tick((p == 8 || p == 9) ? 1'b1 : 1'b0, 1'b1, 8'(p + 2));
    repeat (4) tick(1'b0, 1'b0, 8'd0);
    chk("abort_eol_n", e1.size(), 1);
    chk("abort_vsync_pulses", vp1, 2);
    chk("abort_frame_cnt", int'(frame_cnt1), 3);
    chk("abort_frame_err", int'(frame_err1), 0);
    send_line(0, 21);
    chk("abort_sof_count", s1, 2);
    chk("abort_sof_dout", sd1, 1);
    chk("abort_eol_n2", e1.size(), 2);
    chk("abort_eol_new", (e1.size() > 1) ? e1[1] : -1, 21);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
